eeprom_master: RTL

EEPROM_MASTER -- requirements
Module: eeprom_master

---
 rtl/eeprom_master.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/eeprom_master.sv
// I2C master for 11-bit-address EEPROMs: single-byte write and random read.
// Optional macro EEPROM_MASTER_ACK_CHECK_EN aborts to STOP on a slave NACK and reports ack_err.
module eeprom_master #(
   parameter int         CLK_DIV = 4,
   parameter logic [6:0] DEV_ID  = 7'b1010000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        rw,
   input  logic [10:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic        scl,
   inout  wire         sda
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_CTRL, S_CTRL_ACK, S_ADDR, S_ADDR_ACK, S_RSTART,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RNACK, S_STOP
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] div_cnt;
   logic [1:0]    quarter;
   logic [3:0]    bit_cnt;
   logic          rw_r, rd_phase;
   logic [10:0]   addr_r;
   logic [7:0]    wdata_r, rx_sh, ctrl_byte;
   logic          bit_end, sample_pt, last_bit, sda_low, sda_in, ack_fail;

   assign sda       = sda_low ? 1'b0 : 1'bz;
   assign sda_in    = sda;
   assign busy      = (state != S_IDLE);
   assign ctrl_byte = {DEV_ID, rd_phase};
   assign bit_end   = (quarter == 2'd3) && (div_cnt == DIV_MAX);
   assign sample_pt = (quarter == 2'd2) && (div_cnt == DIV_MAX);
   assign last_bit  = (state == S_ADDR) ? (bit_cnt == 4'd10) : (bit_cnt == 4'd7);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:            if (start) state_nxt = S_START;
         S_START, S_RSTART: if (bit_end) state_nxt = S_CTRL;
         S_CTRL:            if (bit_end && last_bit) state_nxt = S_CTRL_ACK;
         S_CTRL_ACK:        if (bit_end) state_nxt = ack_fail ? S_STOP : (rd_phase ? S_RDATA : S_ADDR);
         S_ADDR:            if (bit_end && last_bit) state_nxt = S_ADDR_ACK;
         S_ADDR_ACK:        if (bit_end) state_nxt = ack_fail ? S_STOP : (rw_r ? S_RSTART : S_WDATA);
         S_WDATA:           if (bit_end && last_bit) state_nxt = S_WDATA_ACK;
         S_WDATA_ACK:       if (bit_end) state_nxt = S_STOP;
         S_RDATA:           if (bit_end && last_bit) state_nxt = S_RNACK;
         S_RNACK:           if (bit_end) state_nxt = S_STOP;
         S_STOP:            if (bit_end) state_nxt = S_IDLE;
         default:           state_nxt = S_IDLE;
      endcase
   end

   // START/RSTART pull SDA low in Q3 with SCL high; STOP releases it in Q3.
   always_comb begin
      scl     = (state == S_IDLE) | quarter[1];
      sda_low = 1'b0;
      case (state)
         S_START, S_RSTART: sda_low = (quarter == 2'd3);
         S_CTRL:            sda_low = !ctrl_byte[3'd7 - bit_cnt[2:0]];
         S_ADDR:            sda_low = !addr_r[4'd10 - bit_cnt];
         S_WDATA:           sda_low = !wdata_r[3'd7 - bit_cnt[2:0]];
         S_STOP:            sda_low = (quarter != 2'd3);
         default:           sda_low = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         quarter  <= 2'd0;
         bit_cnt  <= 4'd0;
         done     <= 1'b0;
         rdata    <= 8'h00;
         rd_phase <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            div_cnt <= '0;
            quarter <= 2'd0;
            bit_cnt <= 4'd0;
            if (start) begin
               rw_r     <= rw;
               addr_r   <= addr;
               wdata_r  <= wdata;
               rd_phase <= 1'b0;
            end
         end else if (state_nxt != state) begin
            div_cnt <= '0;
            quarter <= 2'd0;
            bit_cnt <= 4'd0;
         end else begin
            div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
            if (div_cnt == DIV_MAX) quarter <= quarter + 2'd1;
            if (bit_end) bit_cnt <= bit_cnt + 4'd1;
         end
         if (state == S_RSTART && bit_end) rd_phase <= 1'b1;
         if (state == S_RDATA && sample_pt) rx_sh <= {rx_sh[6:0], sda_in};
         if (state == S_STOP && bit_end) begin
            done <= 1'b1;
            if (rw_r && !ack_err) rdata <= rx_sh;
         end
      end
   end

`ifdef EEPROM_MASTER_ACK_CHECK_EN
   logic nack_seen, ack_err_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         nack_seen <= 1'b0;
         ack_err_r <= 1'b0;
      end else if (state == S_IDLE && start) begin
         nack_seen <= 1'b0;
         ack_err_r <= 1'b0;
      end else if (sample_pt && (state == S_CTRL_ACK || state == S_ADDR_ACK ||
                                 state == S_WDATA_ACK)) begin
         nack_seen <= sda_in;
         if (sda_in) ack_err_r <= 1'b1;
      end
   end

   assign ack_fail = nack_seen;
   assign ack_err  = ack_err_r;
`else
   assign ack_fail = 1'b0;
   assign ack_err  = 1'b0;
`endif

endmodule
